// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DZ} state_t;
  localparam int DIV_WIDTH = 32;
  localparam logic [63:0] DZ_Q = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvs,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qb
);
  logic [WIDTH:0] sh;
  logic [WIDTH-1:0] diff;
  assign sh = {rem, bit_in};
  assign qb = sh >= {1'b0, dvs};
  // sh < 2*dvs, so a successful subtraction always fits in WIDTH bits
  assign diff = sh[WIDTH-1:0] - dvs;
  assign rem_nxt = qb ? diff : sh[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN; otherwise sgn is ignored.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p, p_nxt, dvd, dvs, a_mag, b_mag, q_fix, r_fix;
  logic qb;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa = sgn & a[WIDTH-1];
  assign sb = sgn & b[WIDTH-1];
  // the most negative value negates to itself, which is its correct unsigned magnitude
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -p : p;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = dvd;
  assign r_fix = p;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(p),
    .dvs(dvs),
    .bit_in(dvd[WIDTH-1]),
    .rem_nxt(p_nxt),
    .qb(qb)
  );
  // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      dvd <= '0;
      dvs <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dz <= 1'b0;
      q <= '0;
      r <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          dz <= 1'b0;
          p <= '0;
          dvs <= b_mag;
          cnt <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q <= sa ^ sb;
          neg_r <= sa;
`endif
          state <= (b == '0) ? DZ : CALC;
          dvd <= (b == '0) ? a : a_mag;
        end
        CALC: begin
          p <= p_nxt;
          dvd <= {dvd[WIDTH-2:0], qb};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          q <= q_fix;
          r <= r_fix;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        DZ: begin
          q <= DZ_Q[WIDTH-1:0];
          r <= dvd;
          dz <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider.
module tb_seq_divider;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, dz;
  logic [31:0] q, r;
  int n_vec = 0, n_err = 0;

  seq_divider dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait for done; inputs are scrambled after the accepting edge.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        output int lat, output logic busy_ok);
    a = va; b = vb; sgn = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0001; sgn = ~vs;
    lat = 0; busy_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec += 5;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    if (dz !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", dz); end
    if (q !== 32'h0) begin n_err++; $display("FAIL reset_q got %h want 0", q); end
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_r got %h want 0", r); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    logic bok;
    run_op(32'd100, 32'd7, 1'b0, lat, bok);
    n_vec += 5;
    if (lat !== 33) begin n_err++; $display("FAIL u_latency got %0d want 33", lat); end
    if (bok !== 1'b1) begin n_err++; $display("FAIL u_busy got %b want 1", bok); end
    if (q !== 32'd14) begin n_err++; $display("FAIL u_q got %0d want 14", q); end
    if (r !== 32'd2) begin n_err++; $display("FAIL u_r got %0d want 2", r); end
    if (dz !== 1'b0) begin n_err++; $display("FAIL u_dz got %b want 0", dz); end
    @(posedge clk); #1;
    n_vec += 2;
    if (done !== 1'b0) begin n_err++; $display("FAIL u_done_pulse got %b want 0", done); end
    if (q !== 32'd14) begin n_err++; $display("FAIL u_q_hold got %0d want 14", q); end
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, lat, bok);
    n_vec += 2;
    if (q !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL u_big_q got %h want 0fffffff", q); end
    if (r !== 32'hF) begin n_err++; $display("FAIL u_big_r got %h want f", r); end
    run_op(32'd5, 32'd9, 1'b0, lat, bok);
    n_vec += 2;
    if (q !== 32'd0) begin n_err++; $display("FAIL u_small_q got %0d want 0", q); end
    if (r !== 32'd5) begin n_err++; $display("FAIL u_small_r got %0d want 5", r); end
  endtask

  task automatic test_signed;
    int lat;
    logic bok;
    logic [31:0] eq, er;
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat, bok);
`ifdef SEQ_DIVIDER_SIGNED_EN
    eq = 32'hFFFF_FFF2; er = 32'hFFFF_FFFE;
`else
    eq = 32'd613566742; er = 32'd2;
`endif
    n_vec += 3;
    if (lat !== 33) begin n_err++; $display("FAIL s_latency got %0d want 33", lat); end
    if (q !== eq) begin n_err++; $display("FAIL s_neg_a_q got %h want %h", q, eq); end
    if (r !== er) begin n_err++; $display("FAIL s_neg_a_r got %h want %h", r, er); end
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, lat, bok);
`ifdef SEQ_DIVIDER_SIGNED_EN
    eq = 32'hFFFF_FFF2; er = 32'd2;
`else
    eq = 32'd0; er = 32'd100;
`endif
    n_vec += 2;
    if (q !== eq) begin n_err++; $display("FAIL s_neg_b_q got %h want %h", q, eq); end
    if (r !== er) begin n_err++; $display("FAIL s_neg_b_r got %h want %h", r, er); end
    run_op(32'hFFFF_FF9C, 32'd7, 1'b0, lat, bok);
    n_vec += 2;
    if (q !== 32'd613566742) begin n_err++; $display("FAIL s_unsigned_q got %0d want 613566742", q); end
    if (r !== 32'd2) begin n_err++; $display("FAIL s_unsigned_r got %0d want 2", r); end
  endtask

  task automatic test_div_zero;
    int lat;
    logic bok;
    run_op(32'h1234, 32'h0, 1'b0, lat, bok);
    n_vec += 5;
    if (lat !== 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
    if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_q got %h want ffffffff", q); end
    if (r !== 32'h1234) begin n_err++; $display("FAIL dz_r got %h want 1234", r); end
    if (dz !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", dz); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL dz_busy got %b want 0", busy); end
    run_op(32'd9, 32'd3, 1'b0, lat, bok);
    n_vec += 2;
    if (dz !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", dz); end
    if (q !== 32'd3) begin n_err++; $display("FAIL dz_next_q got %0d want 3", q); end
  endtask

  task automatic test_overflow;
    int lat;
    logic bok;
    logic [31:0] eq, er;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok);
`ifdef SEQ_DIVIDER_SIGNED_EN
    eq = 32'h8000_0000; er = 32'h0;
`else
    eq = 32'h0; er = 32'h8000_0000;
`endif
    n_vec += 3;
    if (q !== eq) begin n_err++; $display("FAIL ovf_q got %h want %h", q, eq); end
    if (r !== er) begin n_err++; $display("FAIL ovf_r got %h want %h", r, er); end
    if (dz !== 1'b0) begin n_err++; $display("FAIL ovf_dz got %b want 0", dz); end
  endtask

  task automatic test_back_to_back;
    int n;
    a = 32'd20; b = 32'd4; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd3;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    n_vec += 3;
    if (n !== 33) begin n_err++; $display("FAIL b2b_first_latency got %0d want 33", n); end
    if (q !== 32'd5) begin n_err++; $display("FAIL b2b_first_q got %0d want 5", q); end
    if (r !== 32'd0) begin n_err++; $display("FAIL b2b_first_r got %0d want 0", r); end
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    n_vec += 3;
    if (n !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d want 33", n); end
    if (q !== 32'd3) begin n_err++; $display("FAIL b2b_second_q got %0d want 3", q); end
    if (r !== 32'd0) begin n_err++; $display("FAIL b2b_second_r got %0d want 0", r); end
  endtask

  task automatic test_reset_mid;
    int dones;
    a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    if (q !== 32'h0) begin n_err++; $display("FAIL rst_mid_q got %h want 0", q); end
    if (r !== 32'h0) begin n_err++; $display("FAIL rst_mid_r got %h want 0", r); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_vec++;
    if (dones !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
